// File: rtl/tilemap_writer_pkg.sv
// Shared tilemap geometry and types; the collision detector imports the same constants.
package tilemap_writer_pkg;

    localparam int unsigned TILEMAP_LENGTH = 2000;
    localparam int unsigned TILEMAP_HEIGHT = 16;
    localparam int unsigned ADDR_W         = 15;
    localparam int unsigned TILE_W         = 3;
    localparam int unsigned X_W            = 11;
    localparam int unsigned Y_W            = 4;
    localparam int unsigned MAP_SIZE       = TILEMAP_LENGTH * TILEMAP_HEIGHT;

    localparam logic [TILE_W-1:0] TILE_EMPTY = TILE_W'(0);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MAP_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TILE_W-1:0] data;
    } tile_wr_t;

endpackage

// File: rtl/tilemap_writer_tile_address_calc.sv
// Row-major tile address: y * TILEMAP_LENGTH + x. Shared with the collision reader.
module tile_address_calc
    import tilemap_writer_pkg::*;
(
    input  logic [X_W-1:0]    x_i,
    input  logic [Y_W-1:0]    y_i,
    output logic [ADDR_W-1:0] addr_c
);

    assign addr_c = ADDR_W'(y_i) * ADDR_W'(TILEMAP_LENGTH) + ADDR_W'(x_i);

endmodule

// File: rtl/tilemap_writer.sv
// Tilemap RAM write port: single-tile writes and full-map clear sweeps.
module tilemap_writer
    import tilemap_writer_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              write_req,
    input  logic [X_W-1:0]    x_location,
    input  logic [Y_W-1:0]    y_location,
    input  logic [TILE_W-1:0] tile_in,
    input  logic              clear_req,
    input  logic [TILE_W-1:0] clear_tile,
    output logic [ADDR_W-1:0] memory_address,
    output logic [TILE_W-1:0] memory_data,
    output logic              memory_wren,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    tile_wr_t          wr_q, wr_d;
    tile_wr_t          out_q, out_d;
    logic              wren_q, wren_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [ADDR_W-1:0] calc_addr_c;
    logic              x_ok_c, y_ok_c, in_range_c;

    tile_address_calc u_addr_calc (
        .x_i    (x_location),
        .y_i    (y_location),
        .addr_c (calc_addr_c)
    );

    assign x_ok_c = (x_location < X_W'(TILEMAP_LENGTH));

    // A row field that covers exactly the map height needs no compare.
    if (TILEMAP_HEIGHT >= (1 << Y_W)) begin : g_y_full
        assign y_ok_c = 1'b1;
    end else begin : g_y_cmp
        assign y_ok_c = (y_location < Y_W'(TILEMAP_HEIGHT));
    end

    assign in_range_c = x_ok_c & y_ok_c;

    // Next-state logic; outputs are decoded from the next state and registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        error_d = 1'b0;
        out_d   = '{addr: '0, data: TILE_EMPTY};
        wren_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    wr_d    = '{addr: '0, data: clear_tile};
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end else if (write_req) begin
                    if (in_range_c) begin
                        wr_d    = '{addr: calc_addr_c, data: tile_in};
                        state_d = ST_WRITE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (state_d == ST_WRITE) begin
            out_d  = wr_d;
            wren_d = 1'b1;
        end else if (state_d == ST_CLEAR) begin
            out_d  = '{addr: cnt_d, data: wr_d.data};
            wren_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= '{addr: '0, data: TILE_EMPTY};
            out_q   <= '{addr: '0, data: TILE_EMPTY};
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            out_q   <= out_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign memory_address = out_q.addr;
    assign memory_data    = out_q.data;
    assign memory_wren    = wren_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_tilemap_writer.sv
// Bench for tilemap_writer: RAM image model, randomized writes, clear sweep and reset abort.
module tb_tilemap_writer;

    localparam int L    = 2000;
    localparam int H    = 16;
    localparam int SIZE = L * H;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        write_req = 1'b0;
    logic [10:0] x_location = '0;
    logic [3:0]  y_location = '0;
    logic [2:0]  tile_in = '0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_tile = '0;
    logic [14:0] memory_address;
    logic [2:0]  memory_data;
    logic        memory_wren;
    logic        busy;
    logic        done;
    logic        error;

    tilemap_writer dut (
        .clock          (clock),
        .resetn         (resetn),
        .write_req      (write_req),
        .x_location     (x_location),
        .y_location     (y_location),
        .tile_in        (tile_in),
        .clear_req      (clear_req),
        .clear_tile     (clear_tile),
        .memory_address (memory_address),
        .memory_data    (memory_data),
        .memory_wren    (memory_wren),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] exp_ram [32768];
    logic [2:0] dut_ram [32768];
    int wq_addr[$];
    int wq_data[$];
    int done_cnt   = 0;
    int err_cnt    = 0;
    int idle_dirty = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // RAM model: capture every write the port performs.
    always @(negedge clock) begin
        if (resetn) begin
            if (memory_wren) begin
                wq_addr.push_back(int'(memory_address));
                wq_data.push_back(int'(memory_data));
                dut_ram[memory_address] = memory_data;
            end else if (memory_address != 15'd0 || memory_data != 3'd0) begin
                idle_dirty++;
            end
            if (done)  done_cnt++;
            if (error) err_cnt++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input int x, input int y, input int t);
        bit ok;
        int a, d0, e0;
        ok = (x < L) && (y < H);
        a  = y * L + x;
        d0 = done_cnt;
        e0 = err_cnt;
        wq_addr.delete();
        wq_data.delete();
        write_req  = 1'b1;
        x_location = 11'(x);
        y_location = 4'(y);
        tile_in    = 3'(t);
        step();
        write_req  = 1'b0;
        x_location = 11'($urandom);
        y_location = 4'($urandom);
        tile_in    = 3'($urandom);
        if (ok) begin
            chk("wr_wren", int'(memory_wren), 1);
            chk("wr_addr", int'(memory_address), a);
            chk("wr_data", int'(memory_data), t);
            chk("wr_busy", int'(busy), 1);
            chk("wr_done_early", int'(done), 0);
            step();
            chk("wr_wren_off", int'(memory_wren), 0);
            chk("wr_done", int'(done), 1);
            chk("wr_busy_done", int'(busy), 1);
            step();
            chk("wr_done_off", int'(done), 0);
            chk("wr_busy_off", int'(busy), 0);
            exp_ram[a] = 3'(t);
        end else begin
            chk("err_pulse", int'(error), 1);
            chk("err_busy", int'(busy), 0);
            chk("err_wren", int'(memory_wren), 0);
            step();
            chk("err_off", int'(error), 0);
            chk("err_busy2", int'(busy), 0);
            step();
        end
        chk("wr_count", wq_addr.size(), ok ? 1 : 0);
        if (ok && wq_addr.size() == 1) begin
            chk("wr_ram_addr", wq_addr[0], a);
            chk("wr_ram_data", wq_data[0], t);
        end
        chk("wr_dones", done_cnt - d0, ok ? 1 : 0);
        chk("wr_errors", err_cnt - e0, ok ? 0 : 1);
    endtask

    initial begin
        int done_at, bad, d0, ctile, x, y;

        for (int i = 0; i < 32768; i++) begin
            exp_ram[i] = 3'd0;
            dut_ram[i] = 3'd0;
        end

        #1 resetn = 1'b0;
        #1;
        chk("rst_addr", int'(memory_address), 0);
        chk("rst_data", int'(memory_data), 0);
        chk("rst_wren", int'(memory_wren), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        #21 resetn = 1'b1;
        step();

        do_write(5, 2, 3);
        do_write(2000, 0, 5);
        do_write(1999, 15, 7);
        do_write(0, 0, 1);
        do_write(2047, 15, 2);

        // Full clear with a simultaneous write and a mid-sweep write request.
        wq_addr.delete();
        wq_data.delete();
        d0 = done_cnt;
        clear_req  = 1'b1;
        clear_tile = 3'd0;
        write_req  = 1'b1;
        x_location = 11'd7;
        y_location = 4'd3;
        tile_in    = 3'd5;
        step();
        clear_req  = 1'b0;
        write_req  = 1'b0;
        clear_tile = 3'd7;
        chk("clr_busy", int'(busy), 1);
        chk("clr_first_addr", int'(memory_address), 0);
        done_at = -1;
        for (int c = 0; c < SIZE + 50; c++) begin
            if (done) begin
                done_at = c;
                break;
            end
            if (c == 100) begin
                chk("clr_addr100", int'(memory_address), 100);
                write_req  = 1'b1;
                x_location = 11'd1;
                y_location = 4'd1;
                tile_in    = 3'd6;
            end else begin
                write_req = 1'b0;
            end
            step();
        end
        write_req = 1'b0;
        chk("clr_done_at", done_at, SIZE);
        chk("clr_busy_at_done", int'(busy), 1);
        step();
        chk("clr_busy_off", int'(busy), 0);
        chk("clr_done_off", int'(done), 0);
        chk("clr_count", wq_addr.size(), SIZE);
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != i || wq_data[i] != 0) bad++;
        chk("clr_seq_bad", bad, 0);
        chk("clr_dones", done_cnt - d0, 1);
        for (int i = 0; i < SIZE; i++) exp_ram[i] = 3'd0;

        // Clear aborted by reset at sweep address 500.
        wq_addr.delete();
        wq_data.delete();
        d0 = done_cnt;
        ctile = int'($urandom_range(1, 7));
        clear_req  = 1'b1;
        clear_tile = 3'(ctile);
        step();
        clear_req = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c == 500) break;
            step();
        end
        chk("abort_addr", int'(memory_address), 500);
        chk("abort_wren_before", int'(memory_wren), 1);
        #1 resetn = 1'b0;
        #1;
        chk("abort_wren", int'(memory_wren), 0);
        chk("abort_addr0", int'(memory_address), 0);
        chk("abort_data0", int'(memory_data), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_error", int'(error), 0);
        step();
        resetn = 1'b1;
        step();
        step();
        chk("abort_no_resume", int'(memory_wren), 0);
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_count", wq_addr.size(), 500);
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != i || wq_data[i] != ctile) bad++;
        chk("abort_seq_bad", bad, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 500; i++) exp_ram[i] = 3'(ctile);

        do_write(0, 15, int'($urandom_range(0, 7)));

        for (int i = 0; i < 40; i++) begin
            x = (i % 5 == 0) ? int'($urandom_range(2000, 2047)) : int'($urandom_range(0, 1999));
            y = int'($urandom_range(0, 15));
            do_write(x, y, int'($urandom_range(0, 7)));
        end

        bad = 0;
        for (int i = 0; i < 32768; i++)
            if (dut_ram[i] !== exp_ram[i]) bad++;
        chk("ram_image", bad, 0);
        chk("idle_outputs_nonzero", idle_dirty, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
